// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl
//   Pedestrian-crossing phase controller. It cycles WALK (green) -> FLASH (yellow)
//   -> STOP (red) -> WALK. Each phase counts down whole seconds from its own
//   duration to 1, paced by an internal prescaler. A pedestrian request shortens
//   STOP, pause freezes time, and a rising edge on change_state skips to the next
//   phase. A quick flag asks for a faster matrix animation near the end of WALK.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous reset, active low
//   pause         in   level, freezes the prescaler and the countdown
//   change_state  in   level, a rising edge forces the next phase
//   ped_req       in   level, pedestrian button
//   red/yellow/green out  one-hot lamps, registered
//   phase         out  0=WALK 1=FLASH 2=STOP
//   sec_tens/ones out  BCD of the remaining seconds
//   quick         out  hurry flag, last QUICK_SEC seconds of WALK
//   ped_wait      out  pedestrian request latched and not yet served
//   tick          out  one-cycle strobe, once per second

module ped_crossing_ctrl #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int WALK_SEC  = 15,
   parameter int FLASH_SEC = 3,
   parameter int STOP_SEC  = 20,
   parameter int QUICK_SEC = 5,
   parameter int PED_SEC   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic       change_state,
   input  logic       ped_req,
   output logic       red,
   output logic       yellow,
   output logic       green,
   output logic [1:0] phase,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic       quick,
   output logic       ped_wait,
   output logic       tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   generate
      if (TICK_DIV < 2 ||
          WALK_SEC < 1  || WALK_SEC > 99  ||
          FLASH_SEC < 1 || FLASH_SEC > 99 ||
          STOP_SEC < 1  || STOP_SEC > 99  ||
          QUICK_SEC < 0 || QUICK_SEC > 99 ||
          PED_SEC < 1   || PED_SEC > STOP_SEC) begin : g_param_err
         $error("ped_crossing_ctrl: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {
      PH_WALK  = 2'd0,
      PH_FLASH = 2'd1,
      PH_STOP  = 2'd2
   } phase_t;

   phase_t          r_phase, w_phase_nx;
   logic [6:0]      r_rem, w_rem_nx;
   logic [PW-1:0]   r_presc, w_presc_nx;
   logic            r_cs_q;
   logic            r_ped_wait, w_ped_wait_nx;
   logic            r_red, r_yellow, r_green, r_quick;
   logic            w_tick, w_edge;

   function automatic phase_t f_next(input phase_t p);
      case (p)
         PH_WALK:  f_next = PH_FLASH;
         PH_FLASH: f_next = PH_STOP;
         default:  f_next = PH_WALK;
      endcase
   endfunction

   function automatic logic [6:0] f_dur(input phase_t p);
      case (p)
         PH_WALK:  f_dur = 7'(WALK_SEC);
         PH_FLASH: f_dur = 7'(FLASH_SEC);
         default:  f_dur = 7'(STOP_SEC);
      endcase
   endfunction

   // The strobe is decoded straight from the count, so pause masks it at once.
   assign w_tick = ~pause & (r_presc == PW'(TICK_DIV - 1));
   assign w_edge = change_state & ~r_cs_q;

   always_comb begin
      w_phase_nx    = r_phase;
      w_rem_nx      = r_rem;
      w_presc_nx    = r_presc;
      w_ped_wait_nx = r_ped_wait;

      if (!pause)
         w_presc_nx = w_tick ? '0 : r_presc + 1'b1;

      // A manual skip wins over the tick and restarts the second, even when
      // paused. Shortening STOP only happens on a cycle with no transition.
      if (w_edge) begin
         w_phase_nx = f_next(r_phase);
         w_rem_nx   = f_dur(w_phase_nx);
         w_presc_nx = '0;
      end else if (w_tick) begin
         if (r_rem > 7'd1) begin
            w_rem_nx = r_rem - 7'd1;
         end else begin
            w_phase_nx = f_next(r_phase);
            w_rem_nx   = f_dur(w_phase_nx);
         end
      end else if (r_phase == PH_STOP && r_ped_wait && r_rem > 7'(PED_SEC)) begin
         w_rem_nx = 7'(PED_SEC);
      end

      if (ped_req && r_phase != PH_WALK)
         w_ped_wait_nx = 1'b1;
      // Entering WALK serves the request, whatever caused the entry.
      if (w_phase_nx == PH_WALK && r_phase != PH_WALK)
         w_ped_wait_nx = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase    <= PH_STOP;
         r_rem      <= 7'(STOP_SEC);
         r_presc    <= '0;
         r_cs_q     <= 1'b0;
         r_ped_wait <= 1'b0;
         r_red      <= 1'b1;
         r_yellow   <= 1'b0;
         r_green    <= 1'b0;
         r_quick    <= 1'b0;
      end else begin
         r_phase    <= w_phase_nx;
         r_rem      <= w_rem_nx;
         r_presc    <= w_presc_nx;
         r_cs_q     <= change_state;
         r_ped_wait <= w_ped_wait_nx;
         // Lamps follow the next state so they change on the same edge as phase.
         r_red      <= (w_phase_nx == PH_STOP);
         r_yellow   <= (w_phase_nx == PH_FLASH);
         r_green    <= (w_phase_nx == PH_WALK);
         r_quick    <= (w_phase_nx == PH_WALK) && (w_rem_nx <= 7'(QUICK_SEC));
      end
   end

   assign red      = r_red;
   assign yellow   = r_yellow;
   assign green    = r_green;
   assign phase    = r_phase;
   assign quick    = r_quick;
   assign ped_wait = r_ped_wait;
   assign tick     = w_tick;
   assign sec_tens = 4'(r_rem / 7'd10);
   assign sec_ones = 4'(r_rem % 7'd10);

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with short durations:
// TICK_DIV=4, WALK=5, FLASH=2, STOP=6, QUICK=3, PED=2.
// Outputs are sampled on the falling clock edge.

module tb_ped_crossing_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pause = 1'b0;
   logic       change_state = 1'b0;
   logic       ped_req = 1'b0;
   logic       red, yellow, green, quick, ped_wait, tick;
   logic [1:0] phase;
   logic [3:0] sec_ones, sec_tens;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ped_crossing_ctrl #(
      .TICK_DIV(4), .WALK_SEC(5), .FLASH_SEC(2), .STOP_SEC(6),
      .QUICK_SEC(3), .PED_SEC(2)
   ) dut (
      .clk(clk), .rst(rst), .pause(pause), .change_state(change_state),
      .ped_req(ped_req), .red(red), .yellow(yellow), .green(green),
      .phase(phase), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .quick(quick), .ped_wait(ped_wait), .tick(tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wait for the next 1 s strobe, then step past the edge that consumes it.
   task automatic step_tick();
      int n = 0;
      while (tick !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (tick !== 1'b1) chk("tick_timeout", tick, 1);
      @(negedge clk);
   endtask

   initial begin
      int seen;

      // Reset state
      @(negedge clk);
      chk("rst_red", red, 1);
      chk("rst_green", green, 0);
      chk("rst_phase", phase, 2);
      chk("rst_bcd", {sec_tens, sec_ones}, 8'h06);
      chk("rst_tick", tick, 0);
      chk("rst_pw", ped_wait, 0);
      rst = 1'b1;

      // 1: tick every 4th cycle, normal phase sequence
      repeat (2) @(negedge clk);
      chk("t1_notick", tick, 0);
      @(negedge clk);
      chk("t1_tick", tick, 1);
      @(negedge clk);
      chk("t1_rem5", sec_ones, 5);
      chk("t1_tick_low", tick, 0);
      repeat (4) step_tick();
      chk("t1_stop_rem1", {phase, sec_ones}, {2'd2, 4'd1});
      step_tick();
      chk("t1_walk_phase", phase, 0);
      chk("t1_walk_lamps", {red, yellow, green}, 3'b001);
      chk("t1_walk_bcd", {sec_tens, sec_ones}, 8'h05);

      // 2: quick flag through WALK
      chk("t2_q5", quick, 0);
      step_tick(); chk("t2_q4", quick, 0);
      step_tick(); chk("t2_q3", quick, 1);
      step_tick(); chk("t2_q2", quick, 1);
      step_tick(); chk("t2_q1", quick, 1);
      step_tick();
      chk("t2_flash", {phase, sec_ones}, {2'd1, 4'd2});
      chk("t2_flash_lamps", {red, yellow, green}, 3'b010);
      chk("t2_q_flash", quick, 0);

      // 4: pause mid-FLASH (prescaler at 1)
      @(negedge clk);
      pause = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (tick) seen++;
      end
      chk("t4_no_tick", seen, 0);
      chk("t4_rem_frozen", sec_ones, 2);
      pause = 1'b0;
      @(negedge clk);
      chk("t4_resume_2", tick, 0);
      @(negedge clk);
      chk("t4_resume_3", tick, 1);
      @(negedge clk);
      chk("t4_rem1", sec_ones, 1);
      step_tick();
      chk("t4_stop", {phase, sec_ones, red}, {2'd2, 4'd6, 1'b1});

      // 3: pedestrian request clips STOP
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      chk("t3_pw_set", ped_wait, 1);
      chk("t3_rem6", sec_ones, 6);
      @(negedge clk);
      chk("t3_clip", {sec_tens, sec_ones}, 8'h02);
      step_tick();
      chk("t3_rem1", {phase, sec_ones}, {2'd2, 4'd1});
      step_tick();
      chk("t3_walk", {phase, sec_ones}, {2'd0, 4'd5});
      chk("t3_pw_clear", ped_wait, 0);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      chk("t3_pw_walk", ped_wait, 0);

      // 5: change_state held 10 cycles in WALK rem 4
      step_tick();
      chk("t5_rem4", {phase, sec_ones}, {2'd0, 4'd4});
      change_state = 1'b1;
      @(negedge clk);
      chk("t5_skip", {phase, sec_ones}, {2'd1, 4'd2});
      chk("t5_tick0", tick, 0);
      repeat (2) @(negedge clk);
      chk("t5_hold_flash", phase, 1);
      @(negedge clk);
      chk("t5_presc_rst", tick, 1);
      @(negedge clk);
      chk("t5_rem1", {phase, sec_ones}, {2'd1, 4'd1});
      repeat (4) @(negedge clk);
      chk("t5_stop", {phase, sec_ones}, {2'd2, 4'd6});
      @(negedge clk);
      change_state = 1'b0;
      chk("t5_one_adv", phase, 2);

      // 5b: edge while paused
      pause = 1'b1;
      @(negedge clk);
      change_state = 1'b1;
      @(negedge clk);
      chk("t5_paused_edge", {phase, sec_ones, green}, {2'd0, 4'd5, 1'b1});
      change_state = 1'b0;
      @(negedge clk);
      pause = 1'b0;

      // 5c: edge coincident with tick
      repeat (2) @(negedge clk);
      @(negedge clk);
      chk("t5_tick_pre", tick, 1);
      change_state = 1'b1;
      @(negedge clk);
      change_state = 1'b0;
      chk("t5_coinc", {phase, sec_ones}, {2'd1, 4'd2});

      // 6: asynchronous reset mid-WALK
      step_tick();
      step_tick();
      change_state = 1'b1;
      @(negedge clk);
      change_state = 1'b0;
      @(negedge clk);
      chk("t6_walk", phase, 0);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_lamps", {red, yellow, green}, 3'b100);
      chk("t6_async_bcd", {sec_tens, sec_ones}, 8'h06);
      chk("t6_async_phase", phase, 2);
      chk("t6_async_quick", quick, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_after", {phase, sec_ones, red}, {2'd2, 4'd6, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
